pipeline_redirect_control: RTL

PIPELINE_REDIRECT_CONTROL -- requirements
Module: pipeline_redirect_control

---
 rtl/pipeline_redirect_control_pkg.sv | 14 +
 rtl/sat_counter16.sv | 30 +++
 rtl/pipeline_redirect_control.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pipeline_redirect_control_pkg.sv
// Shared types and constants for the fetch redirect controller.
package pipeline_redirect_control_pkg;

    localparam int unsigned CntWidth   = 16;
    localparam int unsigned RefillCntW = 3;

    typedef enum logic [1:0] {
        StBoot   = 2'd0,
        StRun    = 2'd1,
        StFlush  = 2'd2,
        StRefill = 2'd3
    } redirect_state_e;

endpackage

// File: rtl/sat_counter16.sv
// Enable-gated up-counter that sticks at all-ones instead of wrapping.
module sat_counter16
    import pipeline_redirect_control_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    output logic [CntWidth-1:0] count_o
);

    logic [CntWidth-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != '1)) begin
            count_d = count_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_redirect_control.sv
// Steers fetch around taken jumps: flushes wrong-path latches, reloads the PC and
// throttles refill, while freezing everything during multi-cycle memory accesses.
module pipeline_redirect_control
    import pipeline_redirect_control_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned REFILL_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall_in,
    input  logic                redirect_req,
    input  logic [XLEN-1:0]     redirect_target,
    input  logic                mem_busy,
    output logic                fetch_en,
    output logic                pc_load,
    output logic [XLEN-1:0]     pc_target,
    output logic                flush_fetch,
    output logic                flush_decoded,
    output logic                pipe_freeze,
    output logic                refill_active,
    output logic [CntWidth-1:0] redirect_cnt,
    output logic [CntWidth-1:0] stall_cnt
);

    localparam logic [RefillCntW-1:0] RefillLoad = RefillCntW'(REFILL_DEPTH);

    redirect_state_e       state_q, state_d;
    logic                  pend_q, pend_d;
    logic [XLEN-1:0]       pend_target_q, pend_target_d;
    logic [XLEN-1:0]       pc_target_q, pc_target_d;
    logic [RefillCntW-1:0] refill_cnt_q, refill_cnt_d;

    logic live;
    logic fetch_ok;
    logic accept;
    logic stall_evt;

    always_comb begin
        live      = (state_q == StRun) || (state_q == StRefill);
        fetch_ok  = !stall_in && !mem_busy;
        // Only RUN/REFILL requests are on the correct path; FLUSH-cycle requests are squashed.
        accept    = live && !mem_busy && (redirect_req || pend_q);

        fetch_en      = 1'b0;
        pc_load       = 1'b0;
        flush_fetch   = 1'b0;
        flush_decoded = 1'b0;
        pipe_freeze   = mem_busy && (state_q != StBoot);
        refill_active = (state_q == StRefill);

        state_d       = state_q;
        pend_d        = pend_q;
        pend_target_d = pend_target_q;
        pc_target_d   = pc_target_q;
        refill_cnt_d  = refill_cnt_q;

        case (state_q)
            StBoot: begin
                state_d = StRun;
            end
            StRun: begin
                fetch_en = fetch_ok;
            end
            StFlush: begin
                if (!mem_busy) begin
                    pc_load       = 1'b1;
                    flush_fetch   = 1'b1;
                    flush_decoded = 1'b1;
                    fetch_en      = 1'b1;
                    refill_cnt_d  = RefillLoad;
                    state_d       = StRefill;
                end
            end
            StRefill: begin
                fetch_en = fetch_ok;
                if (fetch_ok) begin
                    refill_cnt_d = refill_cnt_q - RefillCntW'(1);
                    if (refill_cnt_q == RefillCntW'(1)) begin
                        state_d = StRun;
                    end
                end
            end
            default: begin
                state_d = StBoot;
            end
        endcase

        if (live && mem_busy && redirect_req) begin
            pend_d        = 1'b1;
            pend_target_d = redirect_target;
        end

        // A fresh request in the release cycle is newer than the parked one.
        if (accept) begin
            state_d     = StFlush;
            pend_d      = 1'b0;
            pc_target_d = redirect_req ? redirect_target : pend_target_q;
        end

        stall_evt = live && !fetch_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StBoot;
            pend_q        <= 1'b0;
            pend_target_q <= '0;
            pc_target_q   <= '0;
            refill_cnt_q  <= '0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            pend_target_q <= pend_target_d;
            pc_target_q   <= pc_target_d;
            refill_cnt_q  <= refill_cnt_d;
        end
    end

    assign pc_target = pc_target_q;

    sat_counter16 u_redirect_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (accept),
        .count_o(redirect_cnt)
    );

    sat_counter16 u_stall_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (stall_evt),
        .count_o(stall_cnt)
    );

endmodule
